dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's MEM stage: the slave end of the load/store request interface the core drives.
- Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Performs RV64 sized stores (sb/sh/sw/sd) with byte-lane merging, and sized loads with sign or zero extension.
- Returns each result over a valid/ready response channel, replacing the single-cycle DataMemory model for stall-aware pipeline testing.

Parameters:
- DEPTH, 256: number of 64-bit doublewords in the array; power of two, minimum 2.
- WAIT_CYCLES, 1: wait states between accept and response; 0 is legal.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_funct3  in  3  RV64 funct3: bits[1:0] give size (00 byte, 01 half, 10 word, 11 double); bit2 = unsigned load.
- req_wdata  in  64  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  64  load result, already extended; 0 for stores.
- rsp_err  out  1  misaligned access flag (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0. Array contents are not reset.
- States:
  - IDLE: req_ready=1 (from the first cycle after rst deasserts).
  - WAIT: counts down WAIT_CYCLES.
  - RESP: rsp_valid=1.
- Accept: on a clock edge where req_valid && req_ready. Capture we/addr/funct3/wdata. Next state is WAIT if WAIT_CYCLES>0, else RESP. req_ready drops the following cycle.
- WAIT: counter loads WAIT_CYCLES-1 on accept and decrements each cycle. When it reaches 0, go to RESP.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
- Commit point: array read/write happens on the edge entering RESP.
  - A store modifies only the bytes selected by size and addr[2:0].
  - A load extracts the same lanes.
- Load extension:
  - funct3[2]=0: sign-extend from the lane MSB.
  - funct3[2]=1: zero-extend.
  - 111 is treated as ld.
- Indexing: array index = addr[3+log2(DEPTH)-1:3]; higher address bits are ignored (wrap/alias).
- RESP hold: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready=1. On that edge go to IDLE; req_ready=1 on the next cycle.
- No request is accepted in the same cycle a response is consumed. Maximum throughput is one transaction per WAIT_CYCLES+2 cycles.
- While not in IDLE, req_valid and all request fields are ignored.
- Reset mid-operation: state returns to IDLE and the pending response is dropped. A store still in WAIT is not committed; a store already in RESP is already committed.
- rsp_rdata is 0 for stores and for errored accesses.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - An access whose addr is not a multiple of its size gives rsp_err=1 and rsp_rdata=0.
  - An errored store writes nothing.
  - Latency is unchanged.
- Undefined:
  - addr low bits below the access size are forced to 0 (aligned down).
  - rsp_err is constant 0.

Test Plan:
- Reset, then sd 0x1122334455667788 at 0x10 with WAIT_CYCLES=1: rsp_valid exactly 2 cycles after accept, rdata=0. Then ld 0x10 -> rsp_rdata=0x1122334455667788, rsp_err=0.
- After the above, lb 0x17 -> 0x0000000000000011. Then sb 0x80 at 0x11, lb 0x11 -> 0xFFFFFFFFFFFFFF80, lbu 0x11 -> 0x0000000000000080, ld 0x10 -> 0x1122334455668088.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 and a different address: rsp_valid and rsp_rdata stay stable, req_ready=0, no second accept. Raise rsp_ready: next cycle req_ready=1.
- lw at 0x12, macro defined -> rsp_err=1, rdata=0; sw at 0x12 leaves ld 0x10 unchanged. Macro undefined -> lw 0x12 returns the sign-extended word at 0x10 (0x0000000055668088), rsp_err=0.
- sd 0xDEADBEEF at 0x10 with WAIT_CYCLES=3; assert rst in the second WAIT cycle: all outputs go to reset values. Afterwards ld 0x10 returns the prior value 0x1122334455668088.
- WAIT_CYCLES=0, DEPTH=256: ld at 0x810 (aliases 0x10) -> rsp_valid 1 cycle after accept with the 0x10 data.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store slave with programmable wait states and RV64 sized access.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [CW-1:0]   wait_cnt_reg;
    logic            req_ready_reg, rsp_valid_reg, rsp_err_reg;
    logic [63:0]     rsp_rdata_reg;
    logic            we_reg;
    logic [AW+2:0]   addr_reg;
    logic [2:0]      funct3_reg;
    logic [63:0]     wdata_reg;
    logic [63:0]     mem [DEPTH];

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[63:AW+3];

    logic accept;
    assign accept = (state_reg == IDLE) && req_ready_reg && req_valid;

    // With zero wait states the access commits on the accept edge itself, straight from the request bus.
    logic          commit, c_we;
    logic [AW+2:0] c_addr;
    logic [2:0]    c_f3;
    logic [63:0]   c_wdata;
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            commit  = accept;
            c_we    = req_we;
            c_addr  = req_addr[AW+2:0];
            c_f3    = req_funct3;
            c_wdata = req_wdata;
        end else begin
            commit  = (state_reg == WAIT) && (wait_cnt_reg == '0);
            c_we    = we_reg;
            c_addr  = addr_reg;
            c_f3    = funct3_reg;
            c_wdata = wdata_reg;
        end
    end

    logic [2:0]    align_mask, off;
    logic [7:0]    size_be, be;
    logic          lane_err;
    logic [AW-1:0] idx;
    logic [63:0]   old_word, wdata_sh, merged, rd_sh, load_ext;

    always_comb begin
        align_mask = 3'b111;
        size_be    = 8'h01;
        case (c_f3[1:0])
            2'd0: begin align_mask = 3'b111; size_be = 8'h01; end
            2'd1: begin align_mask = 3'b110; size_be = 8'h03; end
            2'd2: begin align_mask = 3'b100; size_be = 8'h0F; end
            default: begin align_mask = 3'b000; size_be = 8'hFF; end
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        lane_err = |(c_addr[2:0] & ~align_mask);
        off      = c_addr[2:0];
`else
        lane_err = 1'b0;
        off      = c_addr[2:0] & align_mask;
`endif
        be       = size_be << off;
        idx      = c_addr[AW+2:3];
        old_word = mem[idx];
        wdata_sh = c_wdata << {off, 3'b000};
        rd_sh    = old_word >> {off, 3'b000};
        case (c_f3[1:0])
            2'd0:    load_ext = c_f3[2] ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
            2'd1:    load_ext = c_f3[2] ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            2'd2:    load_ext = c_f3[2] ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default: load_ext = rd_sh;
        endcase
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign merged[gi*8 +: 8] = be[gi] ? wdata_sh[gi*8 +: 8] : old_word[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && c_we && !lane_err) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg        <= req_we;
                        addr_reg      <= req_addr[AW+2:0];
                        funct3_reg    <= req_funct3;
                        wdata_reg     <= req_wdata;
                        req_ready_reg <= 1'b0;
                        wait_cnt_reg  <= WAIT_LOAD;
                        state_reg     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (commit) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= lane_err;
                rsp_rdata_reg <= (c_we || lane_err) ? 64'd0 : load_ext;
            end
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES = 1, 3 and 0.
module tb_dmem_responder;
    logic        clk;
    logic [2:0]  rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [63:0] req_addr [3];
    logic [63:0] req_wdata [3];
    logic [63:0] rsp_rdata [3];
    logic [2:0]  req_funct3 [3];

    int tests_run = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        dmem_responder #(
            .DEPTH(256),
            .WAIT_CYCLES(gi == 0 ? 1 : (gi == 1 ? 3 : 0))
        ) u_dut (
            .clk(clk),
            .rst(rst[gi]),
            .req_valid(req_valid[gi]),
            .req_ready(req_ready[gi]),
            .req_we(req_we[gi]),
            .req_addr(req_addr[gi]),
            .req_funct3(req_funct3[gi]),
            .req_wdata(req_wdata[gi]),
            .rsp_valid(rsp_valid[gi]),
            .rsp_ready(rsp_ready[gi]),
            .rsp_rdata(rsp_rdata[gi]),
            .rsp_err(rsp_err[gi])
        );
    end

    localparam logic [63:0] V1 = 64'h1122334455667788;
    localparam logic [63:0] V2 = 64'h1122334455668088;
    localparam logic [63:0] V3 = 64'h0123456789ABCDEF;

    // Runs one complete transaction; lat counts cycles from the accept cycle to rsp_valid (99 = never accepted).
    task automatic xact(input int d, input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we[d] = we; req_funct3[d] = f3; req_addr[d] = addr; req_wdata[d] = wdata;
        req_valid[d] = 1'b1; rsp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            req_valid[d] = 1'b0;
            rdata = 'x; err = 1'bx; lat = 99;
            $display("[TB] dut%0d request never accepted", d);
            return;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[d];
        err = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
        $display("[TB] dut%0d we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 d, we, f3, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst = 3'b111; req_valid = '0; req_we = '0; rsp_ready = '0;
        for (int d = 0; d < 3; d++) begin
            req_addr[d] = '0; req_wdata[d] = '0; req_funct3[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d]} !== 3'b000 || rsp_rdata[d] !== 64'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b vld=%b err=%b rdata=%h, expected all 0",
                         d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
            end
        end
        rst = 3'b000;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 111", req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] r; logic e; int lat;
        xact(0, 1'b1, 3'b011, 64'h10, V1, r, e, lat);
        tests_run++;
        if (lat !== 2 || r !== 64'd0 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL sd_0x10: got lat=%0d rdata=%h err=%b expected lat=2 rdata=0 err=0", lat, r, e);
        end
        xact(0, 1'b0, 3'b011, 64'h10, 64'd0, r, e, lat);
        tests_run++;
        if (r !== V1 || e !== 1'b0 || lat !== 2) begin
            tests_failed++;
            $display("FAIL ld_0x10: got rdata=%h err=%b lat=%0d expected %h err=0 lat=2", r, e, lat, V1);
        end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] r; logic e; int lat;
        logic [2:0]  f3s [7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b011, 3'b101, 3'b010};
        logic        wes [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [63:0] ads [7] = '{64'h17, 64'h11, 64'h11, 64'h11, 64'h10, 64'h16, 64'h14};
        logic [63:0] wds [7] = '{64'd0, 64'h80, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        logic [63:0] exp [7] = '{64'h11, 64'd0, 64'hFFFFFFFFFFFFFF80, 64'h80, V2,
                                 64'h1122, 64'h11223344};
        for (int i = 0; i < 7; i++) begin
            xact(0, wes[i], f3s[i], ads[i], wds[i], r, e, lat);
            tests_run++;
            if (r !== exp[i] || e !== 1'b0) begin
                tests_failed++;
                $display("FAIL lanes_%0d addr=%h f3=%0d: got %h err=%b expected %h err=0",
                         i, ads[i], f3s[i], r, e, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_we[0] = 1'b0; req_funct3[0] = 3'b011; req_addr[0] = 64'h10; req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_addr[0] = 64'h40;
        n = 1;
        @(negedge clk);
        while (!rsp_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL hold_latency: got %0d expected 2", n);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== V2 || req_ready[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_cycle_%0d: got vld=%b rdata=%h rdy=%b expected vld=1 rdata=%h rdy=0",
                         k, rsp_valid[0], rsp_rdata[0], req_ready[0], V2);
            end
            @(negedge clk);
        end
        $display("[TB] dut0 held ld 0x10 for 3 cycles -> rdata=%h", rsp_rdata[0]);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 begin rsp_ready[0] = 1'b0; req_valid[0] = 1'b0; end
        @(negedge clk);
        tests_run++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: got rdy=%b vld=%b expected rdy=1 vld=0", req_ready[0], rsp_valid[0]);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_second_accept: got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        @(negedge clk);
        tests_run++;
        if (req_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_start_ready: got %b expected 1", req_ready[0]);
        end
        req_we[0] = 1'b0; req_funct3[0] = 3'b011; req_addr[0] = 64'h10;
        req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid[0]) cnt++;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        $display("[TB] dut0 back-to-back ld 0x10 -> %0d responses in 12 cycles", cnt);
        tests_run++;
        if (cnt !== 4) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d responses expected 4", cnt);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] r; logic e; int lat;
        logic [63:0] exp_lw, exp_ld;
        logic        exp_err;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_lw = 64'd0; exp_err = 1'b1; exp_ld = V2;
`else
        exp_lw = 64'h0000000055668088; exp_err = 1'b0; exp_ld = 64'h11223344AAAAAAAA;
`endif
        xact(0, 1'b0, 3'b010, 64'h12, 64'd0, r, e, lat);
        tests_run++;
        if (r !== exp_lw || e !== exp_err || lat !== 2) begin
            tests_failed++;
            $display("FAIL lw_0x12: got rdata=%h err=%b lat=%0d expected %h err=%b lat=2", r, e, lat, exp_lw, exp_err);
        end
        xact(0, 1'b1, 3'b010, 64'h12, 64'hAAAAAAAA, r, e, lat);
        tests_run++;
        if (r !== 64'd0 || e !== exp_err) begin
            tests_failed++;
            $display("FAIL sw_0x12: got rdata=%h err=%b expected 0 err=%b", r, e, exp_err);
        end
        xact(0, 1'b0, 3'b011, 64'h10, 64'd0, r, e, lat);
        tests_run++;
        if (r !== exp_ld || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL ld_after_sw: got %h err=%b expected %h err=0", r, e, exp_ld);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; logic e; int lat, n;
        xact(1, 1'b1, 3'b011, 64'h10, V2, r, e, lat);
        tests_run++;
        if (lat !== 4 || r !== 64'd0) begin
            tests_failed++;
            $display("FAIL w3_sd_latency: got lat=%0d rdata=%h expected lat=4 rdata=0", lat, r);
        end
        @(negedge clk);
        req_we[1] = 1'b1; req_funct3[1] = 3'b011; req_addr[1] = 64'h10;
        req_wdata[1] = 64'hDEADBEEF; req_valid[1] = 1'b1;
        n = 0;
        while (!req_ready[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        $display("[TB] dut1 reset during WAIT of sd 0xDEADBEEF at 0x10");
        tests_run++;
        if ({req_ready[1], rsp_valid[1], rsp_err[1]} !== 3'b000 || rsp_rdata[1] !== 64'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got rdy=%b vld=%b err=%b rdata=%h expected all 0",
                     req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]);
        end
        rst[1] = 1'b0;
        xact(1, 1'b0, 3'b011, 64'h10, 64'd0, r, e, lat);
        tests_run++;
        if (r !== V2 || lat !== 4) begin
            tests_failed++;
            $display("FAIL mid_reset_no_commit: got %h lat=%0d expected %h lat=4", r, lat, V2);
        end
    endtask

    task automatic test_alias();
        logic [63:0] r; logic e; int lat;
        xact(2, 1'b1, 3'b011, 64'h10, V3, r, e, lat);
        tests_run++;
        if (lat !== 1 || r !== 64'd0) begin
            tests_failed++;
            $display("FAIL w0_sd_latency: got lat=%0d rdata=%h expected lat=1 rdata=0", lat, r);
        end
        xact(2, 1'b0, 3'b011, 64'h810, 64'd0, r, e, lat);
        tests_run++;
        if (r !== V3 || lat !== 1 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL alias_ld_0x810: got %h lat=%0d err=%b expected %h lat=1 err=0", r, lat, e, V3);
        end
        xact(2, 1'b0, 3'b110, 64'h814, 64'd0, r, e, lat);
        tests_run++;
        if (r !== 64'h0000000001234567) begin
            tests_failed++;
            $display("FAIL alias_lwu_0x814: got %h expected 0000000001234567", r);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_backpressure();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        test_alias();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
